// File: rtl/axicb_wr_channel_switch.sv
// Master-side write channel switch: feeds AW valids to an external round-robin
// arbiter, forwards the granted AW beat and steers W bursts in AW issue order.
module axicb_wr_channel_switch #(
    parameter int REQ_NB      = 4,
    parameter int AWCH_W      = 64,
    parameter int WCH_W       = 41,
    parameter int ORDER_DEPTH = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       srst,
    output logic                       arb_en,
    output logic [REQ_NB-1:0]          arb_req,
    input  logic [REQ_NB-1:0]          arb_grant,
    input  logic [REQ_NB-1:0]          s_awvalid,
    output logic [REQ_NB-1:0]          s_awready,
    input  logic [REQ_NB*AWCH_W-1:0]   s_awch,
    input  logic [REQ_NB-1:0]          s_wvalid,
    output logic [REQ_NB-1:0]          s_wready,
    input  logic [REQ_NB-1:0]          s_wlast,
    input  logic [REQ_NB*WCH_W-1:0]    s_wch,
    output logic                       m_awvalid,
    input  logic                       m_awready,
    output logic [AWCH_W-1:0]          m_awch,
    output logic                       m_wvalid,
    input  logic                       m_wready,
    output logic                       m_wlast,
    output logic [WCH_W-1:0]           m_wch
);

    localparam int IW   = (REQ_NB > 1) ? $clog2(REQ_NB) : 1;
    localparam int IW_D = $clog2(ORDER_DEPTH);

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    localparam logic [IW_D:0]   CNT_ONE  = (IW_D+1)'(1);
    localparam logic [IW_D:0]   CNT_FULL = (IW_D+1)'(ORDER_DEPTH);
    localparam logic [IW_D-1:0] PTR_ONE  = IW_D'(1);

    logic                state_q, state_d;
    logic [IW-1:0]       sel_q, sel_d;
    logic [IW_D-1:0]     wr_ptr_q, wr_ptr_d;
    logic [IW_D-1:0]     rd_ptr_q, rd_ptr_d;
    logic [IW_D:0]       count_q, count_d;
    logic [IW-1:0]       fifo_q [ORDER_DEPTH];
    logic [IW-1:0]       fifo_d [ORDER_DEPTH];

    logic [IW-1:0]       grant_idx;
    logic [IW-1:0]       head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;

    assign arb_req    = s_awvalid;
    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < REQ_NB; i++) begin
            if (arb_grant[i]) begin
                grant_idx = grant_idx | IW'(i);
            end
        end
    end

    // The full check in IDLE reserves the FIFO slot the later BUSY push will use.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        arb_en    = 1'b0;
        m_awvalid = 1'b0;
        s_awready = '0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                arb_en = (|s_awvalid) && !fifo_full;
                if (arb_en && (|arb_grant)) begin
                    sel_d   = grant_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                m_awvalid        = 1'b1;
                s_awready[sel_q] = m_awready;
                if (m_awready) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_awch = '0;
        for (int unsigned i = 0; i < REQ_NB; i++) begin
            if (sel_q == IW'(i)) begin
                m_awch = s_awch[i*AWCH_W +: AWCH_W];
            end
        end
    end

    always_comb begin
        m_wch = '0;
        for (int unsigned i = 0; i < REQ_NB; i++) begin
            if (head == IW'(i)) begin
                m_wch = s_wch[i*WCH_W +: WCH_W];
            end
        end
    end

    always_comb begin
        s_wready = '0;
        m_wvalid = 1'b0;
        m_wlast  = 1'b0;
        if (!fifo_empty) begin
            m_wvalid       = s_wvalid[head];
            m_wlast        = s_wlast[head];
            s_wready[head] = m_wready;
        end
        pop = m_wvalid && m_wready && m_wlast;
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = sel_q;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fifo_q   <= '{default: '0};
        end else if (srst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fifo_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fifo_q   <= fifo_d;
        end
    end

endmodule

// File: tb/tb_axicb_wr_channel_switch.sv
// Scoreboard bench for axicb_wr_channel_switch with a round-robin arbiter model
// and per-port AW/W drivers.
module tb_axicb_wr_channel_switch;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int WW = 41;
    localparam int OD = 4;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic            srst;
    logic            arb_en;
    logic [N-1:0]    arb_req;
    logic [N-1:0]    arb_grant;
    logic [N-1:0]    s_awvalid;
    logic [N-1:0]    s_awready;
    logic [N*AW-1:0] s_awch;
    logic [N-1:0]    s_wvalid;
    logic [N-1:0]    s_wready;
    logic [N-1:0]    s_wlast;
    logic [N*WW-1:0] s_wch;
    logic            m_awvalid;
    logic            m_awready;
    logic [AW-1:0]   m_awch;
    logic            m_wvalid;
    logic            m_wready;
    logic            m_wlast;
    logic [WW-1:0]   m_wch;

    always #5 aclk = ~aclk;

    axicb_wr_channel_switch #(
        .REQ_NB      (N),
        .AWCH_W      (AW),
        .WCH_W       (WW),
        .ORDER_DEPTH (OD)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .srst      (srst),
        .arb_en    (arb_en),
        .arb_req   (arb_req),
        .arb_grant (arb_grant),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_awch    (s_awch),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_wlast   (s_wlast),
        .s_wch     (s_wch),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_awch    (m_awch),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_wlast   (m_wlast),
        .m_wch     (m_wch)
    );

    // Round-robin arbiter model; pointer only moves when the switch enables it.
    logic [1:0] rr_ptr;
    int         g_idx;

    always_comb begin
        arb_grant = '0;
        g_idx     = 0;
        for (int k = 0; k < N; k++) begin
            if (arb_req[(int'(rr_ptr) + k) % N] && arb_grant == '0) begin
                arb_grant[(int'(rr_ptr) + k) % N] = 1'b1;
                g_idx = (int'(rr_ptr) + k) % N;
            end
        end
    end

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rr_ptr <= '0;
        else if (arb_en && (|arb_grant)) rr_ptr <= 2'((g_idx + 1) % N);
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          aw_cnt [N];
    int          aw_sent[N];
    int          w_left [N];
    int          w_sent [N];
    int          blen   [N];
    bit          w_on   [N];
    int          exp_aws[N];
    int          exp_wb [N];
    logic        awr, wr, sr;
    logic [N-1:0] aw_hs_v, w_hs_v;
    logic [63:0] exp_aw[$];
    logic [41:0] exp_w [$];
    int          cyc_n, aw_hs_n, pop_n, first_pop_cyc, last_aw_cyc, max_cnt;

    function automatic logic [63:0] mk_aw(input int p, input int s);
        return 64'hA5A5_0000_0000_0000 | (64'(p) << 16) | 64'(s);
    endfunction

    function automatic logic [WW-1:0] mk_w(input int p, input int b);
        return {1'b1, 8'(p), 32'(b)};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_awvalid[i]        = aw_cnt[i] > 0;
            s_awch[i*AW +: AW]  = mk_aw(i, aw_sent[i]);
            s_wvalid[i]         = w_on[i] && (w_left[i] > 0);
            s_wch[i*WW +: WW]   = mk_w(i, w_sent[i]);
            s_wlast[i]          = (blen[i] > 0) && ((w_sent[i] % blen[i]) == blen[i] - 1);
        end
        m_awready = awr;
        m_wready  = wr;
        srst      = sr;
    endtask

    task automatic sample();
        @(negedge aclk);
        cyc_n++;
        aw_hs_v = s_awvalid & s_awready;
        w_hs_v  = s_wvalid & s_wready;
        if (int'(dut.count_q) > max_cnt) max_cnt = int'(dut.count_q);
        if (m_awvalid && m_awready) begin
            check_eq("aw_expected", exp_aw.size() > 0, 1);
            if (exp_aw.size() > 0) check_eq("aw_payload", m_awch, exp_aw.pop_front());
            aw_hs_n++;
            last_aw_cyc = cyc_n;
        end
        if (m_wvalid && m_wready) begin
            check_eq("w_expected", exp_w.size() > 0, 1);
            if (exp_w.size() > 0) check_eq("w_beat", {m_wlast, m_wch}, exp_w.pop_front());
            if (m_wlast) begin
                pop_n++;
                if (pop_n == 1) first_pop_cyc = cyc_n;
            end
        end
    endtask

    task automatic adv();
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (aw_hs_v[i]) begin aw_cnt[i]--; aw_sent[i]++; end
            if (w_hs_v[i])  begin w_left[i]--; w_sent[i]++; end
        end
        drive();
    endtask

    task automatic add_port(input int p, input int n_aw, input int bl, input bit on);
        aw_cnt[p] += n_aw;
        w_left[p] += n_aw * bl;
        blen[p]    = bl;
        w_on[p]    = on;
    endtask

    task automatic expect_txn(input int p, input int bl);
        exp_aw.push_back(mk_aw(p, exp_aws[p]));
        exp_aws[p]++;
        for (int b = 0; b < bl; b++) begin
            exp_w.push_back({1'(b == bl - 1), mk_w(p, exp_wb[p])});
            exp_wb[p]++;
        end
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        for (int i = 0; i < N; i++) begin
            aw_cnt[i] = 0; aw_sent[i] = 0; w_left[i] = 0; w_sent[i] = 0;
            blen[i] = 1; w_on[i] = 1'b0; exp_aws[i] = 0; exp_wb[i] = 0;
        end
        exp_aw.delete();
        exp_w.delete();
        awr = 1'b0; wr = 1'b0; sr = 1'b0;
        aw_hs_v = '0; w_hs_v = '0;
        cyc_n = 0; aw_hs_n = 0; pop_n = 0; first_pop_cyc = 0; last_aw_cyc = 0; max_cnt = 0;
        drive();
        #3;
        aresetn = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int b;
        b = budget;
        while ((exp_aw.size() + exp_w.size()) > 0 && b > 0) begin
            sample();
            adv();
            b--;
        end
        check_eq(tag, exp_aw.size() + exp_w.size(), 0);
    endtask

    initial begin
        int ae;
        int bud;

        // Reset state
        do_reset();
        sample();
        check_eq("rst_m_awvalid", m_awvalid, 0);
        check_eq("rst_m_wvalid", m_wvalid, 0);
        check_eq("rst_m_wlast", m_wlast, 0);
        check_eq("rst_arb_en", arb_en, 0);
        check_eq("rst_s_awready", s_awready, 0);
        check_eq("rst_s_wready", s_wready, 0);
        check_eq("rst_count", dut.count_q, 0);

        // Single port 2, 3-beat burst
        do_reset();
        add_port(2, 1, 3, 1'b0);
        awr = 1'b1; wr = 1'b1;
        expect_txn(2, 3);
        adv();
        sample();
        check_eq("p2_arb_en_c0", arb_en, 1);
        check_eq("p2_awvalid_c0", m_awvalid, 0);
        adv();
        sample();
        check_eq("p2_awvalid_c1", m_awvalid, 1);
        check_eq("p2_awready_c1", s_awready, 4'b0100);
        w_on[2] = 1'b1;
        adv();
        drain("p2_drain", 40);
        check_eq("p2_count_end", dut.count_q, 0);
        check_eq("p2_pops", pop_n, 1);

        // All four ports, W held off until every AW is in
        do_reset();
        for (int p = 0; p < N; p++) add_port(p, 1, 2, 1'b1);
        awr = 1'b1; wr = 1'b0;
        for (int p = 0; p < N; p++) expect_txn(p, 2);
        adv();
        bud = 30;
        while (aw_hs_n < 4 && bud > 0) begin sample(); adv(); bud--; end
        check_eq("rr_aw_count", aw_hs_n, 4);
        repeat (3) begin sample(); adv(); end
        check_eq("rr_count_held", dut.count_q, 4);
        check_eq("rr_max_count", max_cnt <= 4, 1);
        wr = 1'b1;
        drain("rr_drain", 60);
        check_eq("rr_count_end", dut.count_q, 0);

        // Full FIFO: 5 AWs with W stalled
        do_reset();
        add_port(0, 2, 2, 1'b1);
        for (int p = 1; p < N; p++) add_port(p, 1, 2, 1'b1);
        awr = 1'b1; wr = 1'b0;
        expect_txn(0, 2); expect_txn(1, 2); expect_txn(2, 2); expect_txn(3, 2); expect_txn(0, 2);
        adv();
        bud = 30;
        while (aw_hs_n < 4 && bud > 0) begin sample(); adv(); bud--; end
        ae = 0;
        repeat (5) begin
            sample();
            if (arb_en) ae++;
            adv();
        end
        check_eq("full_arb_en_cycles", ae, 0);
        check_eq("full_aw_count", aw_hs_n, 4);
        check_eq("full_count", dut.count_q, 4);
        wr = 1'b1;
        drain("full_drain", 80);
        check_eq("full_aw5_after_pop", last_aw_cyc - first_pop_cyc, 2);
        check_eq("full_count_end", dut.count_q, 0);

        // Early W on port 1 before its AW
        do_reset();
        add_port(1, 1, 1, 1'b1);
        awr = 1'b0; wr = 1'b1;
        expect_txn(1, 1);
        adv();
        sample();
        check_eq("early_arb_en", arb_en, 1);
        repeat (3) begin
            adv();
            sample();
            check_eq("early_wready_busy", s_wready, 0);
            check_eq("early_wvalid_busy", m_wvalid, 0);
        end
        awr = 1'b1;
        adv();
        sample();
        check_eq("early_aw_hs", aw_hs_n, 1);
        check_eq("early_wready_hs", s_wready, 0);
        check_eq("early_wvalid_hs", m_wvalid, 0);
        adv();
        sample();
        check_eq("early_wvalid_next", m_wvalid, 1);
        check_eq("early_wready_next", s_wready, 4'b0010);
        adv();
        drain("early_drain", 10);
        check_eq("early_count_end", dut.count_q, 0);

        // Simultaneous push and pop with count 1
        do_reset();
        add_port(0, 1, 1, 1'b0);
        awr = 1'b1; wr = 1'b0;
        expect_txn(0, 1); expect_txn(1, 1);
        adv(); sample();
        adv(); sample();
        add_port(1, 1, 1, 1'b0);
        awr = 1'b0;
        adv(); sample();
        adv(); sample();
        check_eq("simul_count_pre", dut.count_q, 1);
        check_eq("simul_awvalid_pre", m_awvalid, 1);
        awr = 1'b1; wr = 1'b1; w_on[0] = 1'b1; w_on[1] = 1'b1;
        adv();
        sample();
        check_eq("simul_aw_hs", aw_hs_n, 2);
        check_eq("simul_pop", pop_n, 1);
        check_eq("simul_wready_old", s_wready, 4'b0001);
        adv();
        sample();
        check_eq("simul_count_post", dut.count_q, 1);
        check_eq("simul_wready_new", s_wready, 4'b0010);
        check_eq("simul_wvalid_new", m_wvalid, 1);
        adv();
        drain("simul_drain", 10);
        check_eq("simul_count_end", dut.count_q, 0);

        // srst while BUSY with two FIFO entries
        do_reset();
        for (int p = 0; p < 3; p++) add_port(p, 1, 1, 1'b1);
        awr = 1'b1; wr = 1'b0;
        expect_txn(0, 0); expect_txn(1, 0);
        adv();
        bud = 20;
        while (aw_hs_n < 2 && bud > 0) begin
            sample();
            if (aw_hs_n >= 2) awr = 1'b0;
            adv();
            bud--;
        end
        sample(); adv();
        sample();
        check_eq("srst_busy_awvalid", m_awvalid, 1);
        check_eq("srst_busy_count", dut.count_q, 2);
        check_eq("srst_busy_wvalid", m_wvalid, 1);
        sr = 1'b1;
        adv(); sample();
        sr = 1'b0;
        adv(); sample();
        check_eq("srst_awvalid", m_awvalid, 0);
        check_eq("srst_count", dut.count_q, 0);
        check_eq("srst_wready", s_wready, 0);
        check_eq("srst_wvalid", m_wvalid, 0);
        check_eq("srst_idle_arb_en", arb_en, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axicb_wr_channel_switch.md
Name: axicb_wr_channel_switch

Overview:
- Downstream consumer of the round-robin arbiter core inside the crossbar's master-side write path.
- Presents per-slave-port AW valid signals to the arbiter as requests and captures the one-hot grant.
- Forwards the granted AW beat to the single master port, then steers W beats in the same order the AW beats were issued, using an order FIFO.
- The arbiter core is instantiated outside this block; the block connects to it through the arb_* ports.

Parameters:
- REQ_NB, 4, number of slave-side requesters (2..8); index width IW = $clog2(REQ_NB).
- AWCH_W, 64, packed AW payload width per port.
- WCH_W, 41, packed W payload width per port (data+strb+user), excluding wlast.
- ORDER_DEPTH, 4, order FIFO entries (power of two, >=2).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous active-high reset
- arb_en  out  1  enable to arbiter core (mask advance)
- arb_req  out  REQ_NB  requests to arbiter core
- arb_grant  in  REQ_NB  one-hot grant from arbiter core
- s_awvalid  in  REQ_NB  per-port AW valid
- s_awready  out  REQ_NB  per-port AW ready
- s_awch  in  REQ_NB*AWCH_W  packed AW payloads, port i at [i*AWCH_W +: AWCH_W]
- s_wvalid  in  REQ_NB  per-port W valid
- s_wready  out  REQ_NB  per-port W ready
- s_wlast  in  REQ_NB  per-port W last
- s_wch  in  REQ_NB*WCH_W  packed W payloads
- m_awvalid  out  1  master AW valid
- m_awready  in  1  master AW ready
- m_awch  out  AWCH_W  master AW payload
- m_wvalid  out  1  master W valid
- m_wready  in  1  master W ready
- m_wlast  out  1  master W last
- m_wch  out  WCH_W  master W payload

Behaviour:
- Reset (aresetn low async, or srst high at a clock edge):
  - FSM goes to IDLE; sel = 0.
  - FIFO empties: wr/rd pointers = 0, count = 0.
  - All outputs are 0 except payload outputs, which follow the muxed input.
- arb_req = s_awvalid at all times.
- AW FSM, two states:
  - IDLE:
    - arb_en = 1 iff |s_awvalid and FIFO not full; otherwise arb_en = 0.
    - When arb_en = 1 and |arb_grant: register sel = encoded arb_grant, then go to BUSY.
    - arb_grant is combinational from the core in the same cycle.
    - Non-one-hot or zero grant is illegal; a zero grant stays in IDLE.
  - BUSY:
    - arb_en = 0; m_awvalid = 1; m_awch = s_awch[sel]; s_awready[sel] = m_awready; all other s_awready = 0.
    - On m_awready: push sel into FIFO, return to IDLE.
- Latency: m_awvalid rises 1 cycle after arbitration. Peak throughput is one AW per 2 cycles.
- m_awvalid and m_awch stay stable in BUSY until the handshake; AXI requires s_awvalid[sel] to stay high.
- FIFO full in IDLE: arb_en held 0, no grant taken, arbiter mask not advanced.
  - Full cannot occur in BUSY, because the IDLE check reserves the entry.
- W routing, with head = FIFO read data:
  - FIFO empty: m_wvalid = 0 and all s_wready = 0.
  - Otherwise: m_wvalid = s_wvalid[head]; m_wch = s_wch[head]; m_wlast = s_wlast[head]; s_wready[head] = m_wready; other s_wready = 0.
  - Pop on m_wvalid & m_wready & m_wlast.
- Simultaneous push and pop in one cycle: count unchanged, pointers both advance.
  - A push into an empty FIFO is visible to W routing the following cycle, so W lags its AW by at least 1 cycle.
- W beats arriving before their AW has been pushed are not accepted: wready stays 0.
- Pointers wrap modulo ORDER_DEPTH; count has width IW_D+1, where IW_D = $clog2(ORDER_DEPTH).
- srst mid-transaction drops all state immediately; in-flight beats are lost by design.

Test Plan:
- Reset, then idle: all valid/ready/arb_en outputs 0; count 0.
- Single port: s_awvalid = 4'b0100, m_awready = 1.
  - Required: arb_en = 1 at cycle 0; m_awvalid with m_awch = port 2 payload at cycle 1; s_awready[2] = 1 at cycle 1.
  - Then a 3-beat W burst on port 2 passes through with m_wlast on beat 3, and the FIFO returns to empty.
- All 4 ports request AW continuously, arbiter grants 0,1,2,3 in turn, m_awready = 1, W bursts of length 2 per port.
  - Required: AW order 0,1,2,3; W beats routed in the same order.
  - FIFO count reaches no more than 4 when W is held off (m_wready = 0).
- Full FIFO: ORDER_DEPTH = 4, m_wready = 0, 5 AW requests.
  - Required: 4 AW handshakes complete; arb_en stays 0 afterwards.
  - The 5th AW issues only after the first wlast pop.
- Early W: port 1 asserts s_wvalid before its AW is granted.
  - Required: s_wready[1] = 0 and m_wvalid = 0 until the cycle after the AW handshake.
- Simultaneous AW handshake and final wlast pop with count = 1: count stays 1, head advances to the new index.
- srst asserted while in BUSY with 2 FIFO entries: next cycle state IDLE, count 0, m_awvalid = 0, all s_wready = 0.
